// File: rtl/serial_add_ctrl_pkg.sv
// Types and helpers shared by the bit-serial adder controller.
`include "serial_add_ctrl_defs.sv"

package serial_add_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = `SAC_STATE_IDLE,
        ST_RUN  = `SAC_STATE_RUN,
        ST_DONE = `SAC_STATE_DONE
    } sac_state_t;

    // One extra bit keeps the counter from wrapping when WIDTH is a power of two.
    function automatic int sac_cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/serial_add_ctrl_defs.sv
// Shared state encoding for the serial-add sequencer family, so every
// sequencer and bench decodes the state register identically.
`ifndef SERIAL_ADD_CTRL_DEFS_SV
`define SERIAL_ADD_CTRL_DEFS_SV

`define SAC_STATE_IDLE 2'd0
`define SAC_STATE_RUN  2'd1
`define SAC_STATE_DONE 2'd2

`endif

// File: rtl/serial_add_ctrl_fa_bit_cell.sv
// One-bit full adder built as two cascaded half adders whose carries are ORed.
module fa_bit_cell (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);

    logic hs1;
    logic hc1;
    logic hc2;

    assign hs1 = x ^ y;
    assign hc1 = x & y;
    assign s   = hs1 ^ ci;
    assign hc2 = hs1 & ci;
    assign co  = hc1 | hc2;

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: latches operands on start, pushes one bit pair
// per clock LSB-first through a single full-adder cell, then pulses done.
module serial_add_ctrl
    import serial_add_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CNT_W = sac_cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    sac_state_t       state;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic             c;
    logic [CNT_W-1:0] cnt;

    logic             cell_s;
    logic             cell_co;
    logic [WIDTH-1:0] sum_next;

    fa_bit_cell u_cell (
        .x  (ra[0]),
        .y  (rb[0]),
        .ci (c),
        .s  (cell_s),
        .co (cell_co)
    );

    // Written this way so WIDTH=1 needs no special-cased slice.
    always_comb begin
        sum_next            = sum >> 1;
        sum_next[WIDTH-1]   = cell_s;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            ra    <= '0;
            rb    <= '0;
            c     <= 1'b0;
            cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        ra    <= a;
                        rb    <= b;
                        c     <= cin;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    ra  <= ra >> 1;
                    rb  <= rb >> 1;
                    c   <= cell_co;
                    sum <= sum_next;
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == LAST_BIT) begin
                        cout  <= cell_co;
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed and randomized checks of serial_add_ctrl at WIDTH=8 and WIDTH=1.
module tb_serial_add_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       start8 = 1'b0;
    logic [7:0] a8 = '0;
    logic [7:0] b8 = '0;
    logic       cin8 = 1'b0;
    logic       busy8;
    logic       done8;
    logic [7:0] sum8;
    logic       cout8;

    logic       start1 = 1'b0;
    logic [0:0] a1 = '0;
    logic [0:0] b1 = '0;
    logic       cin1 = 1'b0;
    logic       busy1;
    logic       done1;
    logic [0:0] sum1;
    logic       cout1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_add_ctrl #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst   (rst),
        .start (start8),
        .a     (a8),
        .b     (b8),
        .cin   (cin8),
        .busy  (busy8),
        .done  (done8),
        .sum   (sum8),
        .cout  (cout8)
    );

    serial_add_ctrl #(.WIDTH(1)) dut1 (
        .clk   (clk),
        .rst   (rst),
        .start (start1),
        .a     (a1),
        .b     (b1),
        .cin   (cin1),
        .busy  (busy1),
        .done  (done1),
        .sum   (sum1),
        .cout  (cout1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns in the DONE cycle; cyc counts clocks from the start edge to done.
    task automatic do_add8(input logic [7:0] ta, input logic [7:0] tb_, input logic tc,
                           output int cyc, output bit tmo);
        a8 = ta; b8 = tb_; cin8 = tc; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        cyc = 0;
        tmo = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            cyc++;
            if (done8) begin
                tmo = 1'b0;
                break;
            end
        end
    endtask

    task automatic do_add1(input logic ta, input logic tb_, input logic tc,
                           output int cyc, output bit tmo);
        a1 = ta; b1 = tb_; cin1 = tc; start1 = 1'b1;
        tick();
        start1 = 1'b0;
        cyc = 0;
        tmo = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            cyc++;
            if (done1) begin
                tmo = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        checks++;
        if ({busy8, done8, sum8, cout8} !== 11'h0) begin
            errors++;
            $display("[TB] FAIL reset8: got busy=%b done=%b sum=%h cout=%b, expected all 0",
                     busy8, done8, sum8, cout8);
        end
        checks++;
        if ({busy1, done1, sum1, cout1} !== 4'h0) begin
            errors++;
            $display("[TB] FAIL reset1: got busy=%b done=%b sum=%h cout=%b, expected all 0",
                     busy1, done1, sum1, cout1);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_ripple();
        int cyc;
        bit tmo;
        a8 = 8'hFF; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        checks++;
        if (busy8 !== 1'b1) begin
            errors++;
            $display("[TB] FAIL ripple_busy_rise: got %b expected 1", busy8);
        end
        cyc = 0;
        tmo = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            cyc++;
            if (done8) begin
                tmo = 1'b0;
                break;
            end
        end
        checks++;
        if (tmo || cyc != 8) begin
            errors++;
            $display("[TB] FAIL ripple_latency: got %0d (timeout=%b) expected 8", cyc, tmo);
        end
        checks++;
        if ({cout8, sum8} !== 9'h100 || busy8 !== 1'b1) begin
            errors++;
            $display("[TB] FAIL ripple_result: got cout=%b sum=%h busy=%b expected cout=1 sum=00 busy=1",
                     cout8, sum8, busy8);
        end
        tick();
        checks++;
        if (busy8 !== 1'b0 || done8 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL ripple_idle: got busy=%b done=%b expected 0 0", busy8, done8);
        end
    endtask

    task automatic test_carry_in();
        int cyc;
        bit tmo;
        do_add8(8'h7F, 8'h00, 1'b1, cyc, tmo);
        checks++;
        if (tmo || {cout8, sum8} !== 9'h080) begin
            errors++;
            $display("[TB] FAIL carry_in: got cout=%b sum=%h (timeout=%b) expected cout=0 sum=80",
                     cout8, sum8, tmo);
        end
        tick();
        do_add8(8'h00, 8'h00, 1'b0, cyc, tmo);
        checks++;
        if (tmo || {cout8, sum8} !== 9'h000) begin
            errors++;
            $display("[TB] FAIL zero_add: got cout=%b sum=%h (timeout=%b) expected cout=0 sum=00",
                     cout8, sum8, tmo);
        end
        tick();
    endtask

    task automatic test_start_ignored();
        int pulses;
        logic [8:0] seen;
        pulses = 0;
        seen = '0;
        a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0; start8 = 1'b1;
        tick();
        for (int e = 1; e <= 14; e++) begin
            start8 = (e == 3 || e == 9);
            a8 = 8'hFF;
            b8 = 8'hFF;
            tick();
            if (done8) begin
                pulses++;
                seen = {cout8, sum8};
            end
        end
        start8 = 1'b0;
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("[TB] FAIL ignore_pulses: got %0d expected 1", pulses);
        end
        checks++;
        if (seen !== 9'h046 || {cout8, sum8} !== 9'h046) begin
            errors++;
            $display("[TB] FAIL ignore_result: got done=%h now=%h expected 046", seen, {cout8, sum8});
        end
        checks++;
        if (busy8 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL ignore_idle: got busy=%b expected 0", busy8);
        end
    endtask

    task automatic test_reset_mid();
        int pulses;
        int cyc;
        bit tmo;
        a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b0; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        tick(); tick(); tick();
        checks++;
        if (busy8 !== 1'b1) begin
            errors++;
            $display("[TB] FAIL midrst_busy_before: got %b expected 1", busy8);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({busy8, done8, sum8, cout8} !== 11'h0) begin
            errors++;
            $display("[TB] FAIL midrst_clear: got busy=%b done=%b sum=%h cout=%b expected all 0",
                     busy8, done8, sum8, cout8);
        end
        tick();
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done8 || busy8) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("[TB] FAIL midrst_no_done: got %0d active cycles expected 0", pulses);
        end
        do_add8(8'h01, 8'h01, 1'b0, cyc, tmo);
        checks++;
        if (tmo || {cout8, sum8} !== 9'h002) begin
            errors++;
            $display("[TB] FAIL midrst_after: got cout=%b sum=%h (timeout=%b) expected cout=0 sum=02",
                     cout8, sum8, tmo);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int t_done[$];
        logic [8:0] held;
        bit hold_bad;
        bit check_hold;
        hold_bad = 1'b0;
        check_hold = 1'b0;
        held = '0;
        a8 = 8'h0F; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
        for (int t = 0; t < 35; t++) begin
            tick();
            if (check_hold && (({cout8, sum8} !== held) || busy8 !== 1'b0)) hold_bad = 1'b1;
            check_hold = 1'b0;
            if (done8) begin
                t_done.push_back(t);
                held = {cout8, sum8};
                check_hold = 1'b1;
                if (held !== 9'h010) hold_bad = 1'b1;
            end
        end
        start8 = 1'b0;
        checks++;
        if (t_done.size() != 3) begin
            errors++;
            $display("[TB] FAIL b2b_count: got %0d done pulses expected 3", t_done.size());
        end else begin
            checks++;
            if (t_done[0] != 8 || t_done[1] != 18 || t_done[2] != 28) begin
                errors++;
                $display("[TB] FAIL b2b_spacing: got %0d %0d %0d expected 8 18 28",
                         t_done[0], t_done[1], t_done[2]);
            end
        end
        checks++;
        if (hold_bad) begin
            errors++;
            $display("[TB] FAIL b2b_hold: got result not 010 or not held in idle, expected 010 held");
        end
        for (int i = 0; i < 12; i++) tick();
        checks++;
        if ({cout8, sum8} !== 9'h010 || busy8 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL idle_hold: got cout=%b sum=%h busy=%b expected cout=0 sum=10 busy=0",
                     cout8, sum8, busy8);
        end
    endtask

    task automatic test_random();
        int cyc;
        bit tmo;
        int bad8;
        int bad1;
        logic [7:0] ra;
        logic [7:0] rb;
        logic rc;
        logic [8:0] exp8;
        logic [1:0] exp1;
        bad8 = 0;
        bad1 = 0;
        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rc = 1'($urandom);
            exp8 = {1'b0, ra} + {1'b0, rb} + {8'h00, rc};
            do_add8(ra, rb, rc, cyc, tmo);
            checks++;
            if (tmo || cyc != 8 || {cout8, sum8} !== exp8) begin
                errors++;
                bad8++;
                if (bad8 <= 5)
                    $display("[TB] FAIL rand8: a=%h b=%h cin=%b got %h cyc=%0d expected %h cyc=8",
                             ra, rb, rc, {cout8, sum8}, cyc, exp8);
            end
            tick();
        end
        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom_range(0, 1));
            rb = 8'($urandom_range(0, 1));
            rc = 1'($urandom);
            exp1 = {1'b0, ra[0]} + {1'b0, rb[0]} + {1'b0, rc};
            do_add1(ra[0], rb[0], rc, cyc, tmo);
            checks++;
            if (tmo || cyc != 1 || {cout1, sum1} !== exp1 || busy1 !== 1'b1) begin
                errors++;
                bad1++;
                if (bad1 <= 5)
                    $display("[TB] FAIL rand1: a=%b b=%b cin=%b got %b cyc=%0d busy=%b expected %b cyc=1",
                             ra[0], rb[0], rc, {cout1, sum1}, cyc, busy1, exp1);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_ripple();
        test_carry_in();
        test_start_ignored();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
